conv_channel_sequencer: RTL and testbench
=========================================

Name: conv_channel_sequencer

Overview:
- Controller that drives one convolver instance across N_CH output channels.
- Per channel it fetches the kernel weights and bias, clears the MAC chain, and streams the channel's activation bytes from the input buffer into the convolver with clock-enable gating.
- It collects every valid output byte and writes it to the output buffer at a channel-linear address.
- Sits between the activation/weight buffers and the output feature-map buffer.

Parameters:
- K, 32, kernel length; weight bus width is 8*K.
- STEP, 8, stride between output windows.
- OUT_LEN, 61, outputs per channel.
- N_CH, 42, number of output channels.
- IN_LEN, K+(OUT_LEN-1)*STEP (=512), activations streamed per channel.
- ACT_AW, 12, activation address width.
- OUT_AW, 12, output address width.
- CH_W, 6, channel index width.
- DRAIN_MAX, 64, maximum drain cycles per channel before error.

Ports:
- clk  in  1  clock; all logic on rising edge.
- global_rst  in  1  synchronous, active-high reset.
- start  in  1  begin a full N_CH run; honoured only in IDLE.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the last channel completes.
- err  out  1  sticky drain-timeout flag; cleared by an accepted start.
- ch_idx  out  CH_W  current channel.
- wb_rd_en  out  1  weight/bias read strobe.
- weight_in  in  8*K  weight read data, 1-cycle latency.
- bias_in  in  8  signed bias read data, 1-cycle latency.
- conv_weight  out  8*K  registered weights to convolver.
- conv_bias  out  8  registered bias to convolver.
- conv_rst  out  1  convolver clear.
- conv_ce  out  1  convolver clock enable.
- conv_act  out  8  activation byte.
- act_rd_en  out  1  activation read strobe.
- act_rd_addr  out  ACT_AW  activation read address.
- act_rd_data  in  8  activation read data, 1-cycle latency.
- conv_valid  in  1  convolver output valid.
- conv_data  in  8  convolver output byte.
- out_ready  in  1  output buffer can accept a write.
- out_wr_en  out  1  output write strobe.
- out_wr_addr  out  OUT_AW  output write address.
- out_wr_data  out  8  output write data.

Behaviour:
- Reset values: every output is 0, state is IDLE, all counters are 0. global_rst asserted in any state returns to IDLE within one cycle; no done pulse is issued and err is cleared.
- IDLE:
  - start=1 sets ch=0, clears err, goes to WB_REQ.
  - start is ignored while busy.
- WB_REQ:
  - wb_rd_en=1 for one cycle, with wb_ch=ch_idx; go to WB_LAT.
- WB_LAT:
  - Latch weight_in into conv_weight and bias_in into conv_bias; go to CLR.
  - conv_weight and conv_bias are held constant until the next WB_LAT.
- CLR:
  - conv_rst=1 for exactly one cycle.
  - Clear issued_cnt, out_cnt, drain_cnt and the act_q valid bit; go to RUN.
- RUN (one-entry prefetch register act_q plus a valid bit):
  - act_rd_en = out_ready & (issued_cnt<IN_LEN) & (!act_q_v | conv_ce).
  - act_rd_addr = issued_cnt; issued_cnt increments on each read.
  - The returned byte loads act_q one cycle after the read.
  - conv_ce = act_q_v & out_ready; conv_act = act_q.
  - out_ready=0 freezes reads, ce and all counters, with no byte lost or duplicated.
  - Throughput is one activation per cycle with no bubbles while out_ready=1.
  - Exit to DRAIN when issued_cnt=IN_LEN and act_q has been consumed.
- DRAIN:
  - conv_ce = out_ready; conv_act = 0.
  - drain_cnt increments on each enabled cycle.
  - When drain_cnt reaches DRAIN_MAX with out_cnt<OUT_LEN: set err, go to NEXT.
- Output capture (RUN and DRAIN):
  - out_wr_en = conv_valid & conv_ce, combinational and only while out_cnt<OUT_LEN.
  - out_wr_addr = ch_idx*OUT_LEN + out_cnt, truncated to OUT_AW; out_wr_data = conv_data.
  - out_cnt increments per write.
  - conv_valid pulses beyond OUT_LEN are dropped.
  - Reaching out_cnt=OUT_LEN in DRAIN goes to NEXT. If reached in RUN, streaming completes first, then DRAIN exits immediately.
- NEXT:
  - If ch_idx=N_CH-1: done=1 for one cycle, go to IDLE.
  - Otherwise increment ch_idx and go to WB_REQ.
- Simultaneous events: a write and the out_cnt terminal condition in the same cycle count the write. start coinciding with global_rst is ignored.

Test Plan:
- Nominal run with K=4, STEP=2, OUT_LEN=3, N_CH=2 (IN_LEN=8), out_ready=1, model convolver:
  - expect act addresses 0..7 per channel and two wb_rd_en pulses;
  - expect exactly one conv_rst per channel;
  - expect 6 writes at addresses 0..5;
  - expect done once and busy low one cycle later.
- Back-pressure: toggle out_ready every 3 cycles during RUN -> conv_act sequence equals act_rd_data sequence exactly, and no conv_ce while out_ready=0.
- Drain timeout: model emits only 2 of 3 outputs on ch0 -> err=1 after DRAIN_MAX enabled drain cycles; ch1 still runs; done pulses; err is cleared by the next start.
- Excess outputs: model emits 5 valids per channel -> only 3 writes per channel, and addresses never cross the channel boundary.
- Reset mid-RUN (ch=1, issued_cnt=4): assert global_rst for 1 cycle -> all outputs 0 next cycle, no done; a new start restarts at ch 0, address 0.
- start pulsed while busy -> ignored: ch_idx is unchanged and only one done pulse occurs per run.

Source files
------------

// File: rtl/conv_channel_sequencer_if.sv
// Bus bundle between the channel sequencer and its surroundings: the
// weight/bias buffer, the activation buffer, the convolver instance and the
// output feature-map buffer.
//   master : sequencer side (drives strobes, addresses, convolver controls)
//   slave  : environment side (drives read data, convolver results, out_ready)
interface conv_channel_sequencer_if #(
  parameter int K      = 32,
  parameter int ACT_AW = 12,
  parameter int OUT_AW = 12
);
  logic              wb_rd_en;
  logic [8*K-1:0]    weight_in;
  logic [7:0]        bias_in;
  logic [8*K-1:0]    conv_weight;
  logic [7:0]        conv_bias;
  logic              conv_rst;
  logic              conv_ce;
  logic [7:0]        conv_act;
  logic              act_rd_en;
  logic [ACT_AW-1:0] act_rd_addr;
  logic [7:0]        act_rd_data;
  logic              conv_valid;
  logic [7:0]        conv_data;
  logic              out_ready;
  logic              out_wr_en;
  logic [OUT_AW-1:0] out_wr_addr;
  logic [7:0]        out_wr_data;

  modport master (
    output wb_rd_en, conv_weight, conv_bias, conv_rst, conv_ce, conv_act,
           act_rd_en, act_rd_addr, out_wr_en, out_wr_addr, out_wr_data,
    input  weight_in, bias_in, act_rd_data, conv_valid, conv_data, out_ready
  );

  modport slave (
    input  wb_rd_en, conv_weight, conv_bias, conv_rst, conv_ce, conv_act,
           act_rd_en, act_rd_addr, out_wr_en, out_wr_addr, out_wr_data,
    output weight_in, bias_in, act_rd_data, conv_valid, conv_data, out_ready
  );
endinterface

// File: rtl/conv_channel_sequencer.sv
// Drives one convolver across N_CH output channels. Per channel: fetch
// weights/bias, clear the MAC chain, stream IN_LEN activation bytes with
// clock-enable gating, then drain until OUT_LEN outputs have been written to
// the output buffer at ch_idx*OUT_LEN + n.
// Ports:
//   clk, global_rst (sync, active high), start (accepted only in IDLE)
//   busy (not IDLE), done (1-cycle pulse after last channel),
//   err (sticky drain timeout, cleared by accepted start), ch_idx
//   bus : conv_channel_sequencer_if.master (buffers + convolver signals)
module conv_channel_sequencer #(
  parameter int K         = 32,
  parameter int STEP      = 8,
  parameter int OUT_LEN   = 61,
  parameter int N_CH      = 42,
  parameter int IN_LEN    = K + (OUT_LEN - 1) * STEP,
  parameter int ACT_AW    = 12,
  parameter int OUT_AW    = 12,
  parameter int CH_W      = 6,
  parameter int DRAIN_MAX = 64
) (
  input  logic            clk,
  input  logic            global_rst,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [CH_W-1:0] ch_idx,
  conv_channel_sequencer_if.master bus
);

  localparam int IC_W = $clog2(IN_LEN + 1);
  localparam int OC_W = $clog2(OUT_LEN + 1);
  localparam int DC_W = $clog2(DRAIN_MAX + 1);

  localparam logic [IC_W-1:0] IN_LEN_C   = IC_W'(IN_LEN);
  localparam logic [OC_W-1:0] OUT_LEN_C  = OC_W'(OUT_LEN);
  localparam logic [OC_W-1:0] OUT_LAST   = OC_W'(OUT_LEN - 1);
  localparam logic [DC_W-1:0] DRAIN_LAST = DC_W'(DRAIN_MAX - 1);
  localparam logic [CH_W-1:0] CH_LAST    = CH_W'(N_CH - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WB_REQ, S_WB_LAT, S_CLR, S_RUN, S_DRAIN, S_NEXT
  } state_t;

  state_t state, state_n;

  logic [IC_W-1:0] issued_cnt;
  logic [OC_W-1:0] out_cnt;
  logic [DC_W-1:0] drain_cnt;
  logic            rd_pend;   // read issued last cycle, data on act_rd_data now
  logic [7:0]      act_q;
  logic            act_q_v;
  logic [7:0]      sk_q;      // catches a returning byte when act_q is stalled
  logic            sk_v;
  logic            act_free;
  logic            err_set;

  always_comb begin
    state_n         = state;
    busy            = (state != S_IDLE);
    done            = 1'b0;
    err_set         = 1'b0;
    act_free        = 1'b0;
    bus.wb_rd_en    = 1'b0;
    bus.conv_rst    = 1'b0;
    bus.conv_ce     = 1'b0;
    bus.conv_act    = '0;
    bus.act_rd_en   = 1'b0;
    bus.act_rd_addr = '0;
    bus.out_wr_en   = 1'b0;
    bus.out_wr_addr = '0;
    bus.out_wr_data = '0;

    if (state == S_RUN)   bus.conv_ce = act_q_v & bus.out_ready;
    if (state == S_DRAIN) bus.conv_ce = bus.out_ready;

    if ((state == S_RUN || state == S_DRAIN) && bus.conv_valid && bus.conv_ce &&
        out_cnt < OUT_LEN_C) begin
      bus.out_wr_en   = 1'b1;
      bus.out_wr_addr = OUT_AW'(ch_idx) * OUT_AW'(OUT_LEN) + OUT_AW'(out_cnt);
      bus.out_wr_data = bus.conv_data;
    end

    unique case (state)
      S_IDLE:   if (start) state_n = S_WB_REQ;
      S_WB_REQ: begin
        bus.wb_rd_en = 1'b1;
        state_n      = S_WB_LAT;
      end
      S_WB_LAT: state_n = S_CLR;
      S_CLR: begin
        bus.conv_rst = 1'b1;
        state_n      = S_RUN;
      end
      S_RUN: begin
        bus.conv_act = act_q;
        act_free     = !act_q_v || bus.conv_ce;
        // A read is only launched when its returning byte is guaranteed a
        // slot (act_q or the skid), so back-pressure never drops a byte.
        bus.act_rd_en   = bus.out_ready && (issued_cnt < IN_LEN_C) && act_free && !sk_v;
        bus.act_rd_addr = ACT_AW'(issued_cnt);
        if (issued_cnt == IN_LEN_C && !rd_pend && !sk_v && act_free)
          state_n = S_DRAIN;
      end
      S_DRAIN: begin
        if (out_cnt == OUT_LEN_C || (bus.out_wr_en && out_cnt == OUT_LAST)) begin
          state_n = S_NEXT;
        end else if (bus.conv_ce && drain_cnt == DRAIN_LAST) begin
          err_set = 1'b1;
          state_n = S_NEXT;
        end
      end
      S_NEXT: begin
        if (ch_idx == CH_LAST) begin
          done    = 1'b1;
          state_n = S_IDLE;
        end else begin
          state_n = S_WB_REQ;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (global_rst) begin
      state           <= S_IDLE;
      ch_idx          <= '0;
      err             <= 1'b0;
      bus.conv_weight <= '0;
      bus.conv_bias   <= '0;
      issued_cnt      <= '0;
      out_cnt         <= '0;
      drain_cnt       <= '0;
      rd_pend         <= 1'b0;
      act_q           <= '0;
      act_q_v         <= 1'b0;
      sk_q            <= '0;
      sk_v            <= 1'b0;
    end else begin
      state   <= state_n;
      rd_pend <= bus.act_rd_en;

      unique case (state)
        S_IDLE: if (start) begin
          ch_idx <= '0;
          err    <= 1'b0;
        end
        S_WB_LAT: begin
          bus.conv_weight <= bus.weight_in;
          bus.conv_bias   <= bus.bias_in;
        end
        S_CLR: begin
          issued_cnt <= '0;
          out_cnt    <= '0;
          drain_cnt  <= '0;
          act_q_v    <= 1'b0;
          sk_v       <= 1'b0;
        end
        S_RUN: begin
          if (act_free) begin
            if (sk_v) begin
              act_q   <= sk_q;
              act_q_v <= 1'b1;
              sk_v    <= 1'b0;
            end else if (rd_pend) begin
              act_q   <= bus.act_rd_data;
              act_q_v <= 1'b1;
            end else begin
              act_q_v <= 1'b0;
            end
          end else if (rd_pend) begin
            sk_q <= bus.act_rd_data;
            sk_v <= 1'b1;
          end
        end
        S_NEXT: if (ch_idx != CH_LAST) ch_idx <= ch_idx + 1'b1;
        default: ;
      endcase

      if (err_set)                           err        <= 1'b1;
      if (bus.act_rd_en)                     issued_cnt <= issued_cnt + 1'b1;
      if (bus.out_wr_en)                     out_cnt    <= out_cnt + 1'b1;
      if (state == S_DRAIN && bus.conv_ce)   drain_cnt  <= drain_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_conv_channel_sequencer.sv
// Scoreboarded bench for conv_channel_sequencer with K=4, STEP=2, OUT_LEN=3,
// N_CH=2 (IN_LEN=8). Small behavioural models stand in for the weight
// buffer, activation buffer and convolver.
module tb_conv_channel_sequencer;
  localparam int TK = 4, TSTEP = 2, TOL = 3, TNCH = 2, TIN = 8, TDM = 64;

  logic       clk = 1'b0;
  logic       global_rst, start;
  logic       busy, done, err;
  logic [5:0] ch_idx;

  always #5 clk = ~clk;

  conv_channel_sequencer_if #(.K(TK), .ACT_AW(12), .OUT_AW(12)) bus ();

  conv_channel_sequencer #(
    .K(TK), .STEP(TSTEP), .OUT_LEN(TOL), .N_CH(TNCH), .ACT_AW(12),
    .OUT_AW(12), .CH_W(6), .DRAIN_MAX(TDM)
  ) dut (
    .clk(clk), .global_rst(global_rst), .start(start), .busy(busy),
    .done(done), .err(err), .ch_idx(ch_idx), .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  function automatic logic [7:0] amem(input int a);
    return 8'(a * 13 + 5);
  endfunction
  function automatic logic [8*TK-1:0] wpat(input int c);
    logic [7:0] b;
    b = 8'(8'h10 + c);
    return {b, b, b, b};
  endfunction
  function automatic logic [7:0] bpat(input int c);
    return 8'(8'hF0 - c);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic extra(input string name, input logic [63:0] act);
    checks++;
    errors++;
    $display("FAIL %s got unexpected %0h expected none", name, act);
  endtask

  // ---------------- environment models ----------------
  always @(posedge clk) begin
    if (global_rst) begin
      bus.weight_in <= '0;
      bus.bias_in   <= '0;
    end else if (bus.wb_rd_en) begin
      bus.weight_in <= wpat(int'(ch_idx));
      bus.bias_in   <= bpat(int'(ch_idx));
    end
  end

  always @(posedge clk) begin
    if (global_rst)         bus.act_rd_data <= '0;
    else if (bus.act_rd_en) bus.act_rd_data <= amem(int'(bus.act_rd_addr));
  end

  // Convolver: counts enabled samples since its clear; emits outputs once K
  // samples are in, every STEP samples (or every sample when dense), up to a
  // per-channel limit. Data = 16*channel + output number.
  logic model_clr;
  int   m_cnt, m_emit, m_rsts, m_lim;
  int   lim0, lim1;
  bit   dense;

  always @(posedge clk) begin
    if (model_clr) begin
      m_cnt <= 0; m_emit <= 0; m_rsts <= 0;
    end else if (bus.conv_rst) begin
      m_cnt <= 0; m_emit <= 0; m_rsts <= m_rsts + 1;
    end else if (bus.conv_ce) begin
      m_cnt <= m_cnt + 1;
      if (bus.conv_valid) m_emit <= m_emit + 1;
    end
  end

  always_comb begin
    m_lim = (m_rsts <= 1) ? lim0 : lim1;
    bus.conv_valid = (m_rsts > 0) && (m_cnt >= TK) && (m_emit < m_lim) &&
                     (dense || ((m_cnt - TK) % TSTEP == 0));
    bus.conv_data  = 8'((m_rsts - 1) * 16 + m_emit);
  end

  // out_ready driver: constant 1, or toggling every 3 cycles when bp_en.
  bit bp_en = 1'b0;
  int bp_cnt = 0;
  always @(posedge clk) begin
    #1;
    if (!bp_en) begin
      bus.out_ready = 1'b1;
      bp_cnt = 0;
    end else begin
      bp_cnt++;
      if (bp_cnt == 3) begin
        bus.out_ready = ~bus.out_ready;
        bp_cnt = 0;
      end
    end
  end

  // ---------------- scoreboard ----------------
  int          q_wb[$], q_clr[$], q_done[$];
  logic [11:0] q_addr[$];
  logic [7:0]  q_act[$];
  logic [19:0] q_wr[$];
  int          ce_in_ch = 0, drain_seen = 0, done_cnt = 0;
  bit          busy_next = 1'b0;

  always @(negedge clk) begin
    if (busy_next) begin
      chk("busy_after_done", busy, 0);
      busy_next = 1'b0;
    end
    if (bus.wb_rd_en) begin
      if (q_wb.size() == 0) extra("wb_rd_en", ch_idx);
      else chk("wb_ch", ch_idx, q_wb.pop_front());
    end
    if (bus.conv_rst) begin
      ce_in_ch   = 0;
      drain_seen = 0;
      if (q_clr.size() == 0) extra("conv_rst", ch_idx);
      else begin
        int c;
        c = q_clr.pop_front();
        chk("conv_weight", bus.conv_weight, wpat(c));
        chk("conv_bias", bus.conv_bias, bpat(c));
      end
    end
    if (!bus.out_ready) chk("ce_gated", bus.conv_ce, 0);
    if (bus.conv_ce) begin
      if (ce_in_ch < TIN) begin
        if (q_act.size() == 0) extra("conv_act", bus.conv_act);
        else chk("conv_act", bus.conv_act, q_act.pop_front());
      end else begin
        drain_seen++;
      end
      ce_in_ch++;
    end
    if (bus.act_rd_en) begin
      if (q_addr.size() == 0) extra("act_addr", bus.act_rd_addr);
      else chk("act_addr", bus.act_rd_addr, q_addr.pop_front());
    end
    if (bus.out_wr_en) begin
      if (q_wr.size() == 0) extra("out_wr", {bus.out_wr_addr, bus.out_wr_data});
      else chk("out_wr", {bus.out_wr_addr, bus.out_wr_data}, q_wr.pop_front());
    end
    if (done) begin
      done_cnt++;
      busy_next = 1'b1;
      if (q_done.size() == 0) extra("done", done);
      else void'(q_done.pop_front());
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_run(input int l0, input int l1);
    for (int c = 0; c < TNCH; c++) begin
      int lim;
      lim = (c == 0) ? l0 : l1;
      q_wb.push_back(c);
      q_clr.push_back(c);
      for (int a = 0; a < TIN; a++) begin
        q_addr.push_back(12'(a));
        q_act.push_back(amem(a));
      end
      for (int j = 0; j < TOL; j++)
        if (j < lim) q_wr.push_back({12'(c * TOL + j), 8'(c * 16 + j)});
    end
    q_done.push_back(1);
  endtask

  task automatic clear_model();
    model_clr = 1'b1;
    step();
    model_clr = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      step();
      if (done) seen = 1'b1;
    end
    if (!seen) extra({tag, "_done_timeout"}, 0);
    step();
    step();
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_outs"}, {busy, done, err, ch_idx, bus.wb_rd_en, bus.conv_rst, bus.conv_ce,
                         bus.conv_act, bus.act_rd_en, bus.act_rd_addr, bus.out_wr_en,
                         bus.out_wr_addr, bus.out_wr_data}, 0);
    chk({tag, "_wb_regs"}, {bus.conv_weight, bus.conv_bias}, 0);
  endtask

  initial begin
    global_rst = 1'b1; start = 1'b0; model_clr = 1'b1;
    lim0 = TOL; lim1 = TOL; dense = 1'b0;
    repeat (3) step();
    global_rst = 1'b0; model_clr = 1'b0;
    check_idle_outputs("reset");

    // Nominal run; start re-pulsed while busy must be ignored.
    push_run(TOL, TOL);
    pulse_start();
    begin
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < 500 && !hit; i++) begin
        step();
        if (ch_idx == 1) hit = 1'b1;
      end
      if (!hit) extra("reach_ch1_timeout", 0);
    end
    pulse_start();
    chk("ch_hold", ch_idx, 1);
    wait_done("nominal");
    chk("nominal_err", err, 0);
    chk("nominal_done_cnt", done_cnt, 1);

    // Back-pressure run.
    clear_model();
    push_run(TOL, TOL);
    bp_en = 1'b1;
    pulse_start();
    wait_done("bp");
    bp_en = 1'b0;
    chk("bp_done_cnt", done_cnt, 2);

    // Drain timeout on ch0 (only 2 of 3 outputs).
    clear_model();
    lim0 = 2;
    push_run(2, TOL);
    pulse_start();
    begin
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < 500 && !hit; i++) begin
        step();
        if (err) hit = 1'b1;
      end
      if (!hit) extra("err_timeout", 0);
      chk("drain_cycles", drain_seen, TDM);
    end
    wait_done("timeout");
    chk("err_sticky", err, 1);

    // Excess outputs: dense valids, 5 per channel; accepted start clears err.
    clear_model();
    lim0 = 5; lim1 = 5; dense = 1'b1;
    push_run(5, 5);
    pulse_start();
    chk("err_cleared", err, 0);
    wait_done("excess");
    chk("excess_done_cnt", done_cnt, 4);

    // Reset in RUN at ch 1 once issued_cnt reaches 4.
    clear_model();
    lim0 = TOL; lim1 = TOL; dense = 1'b0;
    push_run(TOL, TOL);
    pulse_start();
    begin
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < 500 && !hit; i++) begin
        step();
        if (ch_idx == 1 && bus.act_rd_en && bus.act_rd_addr == 12'd3) hit = 1'b1;
      end
      if (!hit) extra("reach_addr3_timeout", 0);
    end
    step();
    global_rst = 1'b1;
    step();
    global_rst = 1'b0;
    check_idle_outputs("midrst");
    chk("midrst_no_done", done_cnt, 4);
    q_wb.delete(); q_clr.delete(); q_addr.delete(); q_act.delete();
    q_wr.delete(); q_done.delete();

    // Restart after reset begins at ch 0, address 0.
    clear_model();
    push_run(TOL, TOL);
    pulse_start();
    wait_done("restart");
    chk("restart_done_cnt", done_cnt, 5);

    chk("queues_empty", q_wb.size() + q_clr.size() + q_addr.size() + q_act.size() +
                        q_wr.size() + q_done.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
